// File: rtl/multicycle_ctrl_seq.sv
// Multicycle control sequencer for the 32-bit bus CPU: fetch/execute micro-state FSM
// with memory handshake/timeout, multicycle MUL/DIV hold, Stop/Go pause and illegal-opcode flag.
module multicycle_ctrl_seq #(
    parameter int unsigned MULDIV_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT   = 0
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] IR,
    input  logic        CON_FF,
    input  logic        MemReady,
    input  logic        Stop,
    input  logic        Go,
    output logic        Run,
    output logic        Fault,
    output logic        Illegal,
    output logic [3:0]  BusSel,
    output logic [2:0]  RegSel,
    output logic [10:0] Ld,
    output logic        IncPC,
    output logic        Read,
    output logic        Write,
    output logic [3:0]  AluOp
);

    localparam int unsigned CNT_MAX = (MULDIV_CYCLES > MEM_TIMEOUT) ? MULDIV_CYCLES : MEM_TIMEOUT;
    localparam int unsigned CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    localparam logic [4:0] OP_LD   = 5'h00;
    localparam logic [4:0] OP_LDI  = 5'h01;
    localparam logic [4:0] OP_ST   = 5'h02;
    localparam logic [4:0] OP_ADD  = 5'h03;
    localparam logic [4:0] OP_OR   = 5'h0A;
    localparam logic [4:0] OP_ADDI = 5'h0B;
    localparam logic [4:0] OP_ANDI = 5'h0C;
    localparam logic [4:0] OP_ORI  = 5'h0D;
    localparam logic [4:0] OP_MUL  = 5'h0E;
    localparam logic [4:0] OP_DIV  = 5'h0F;
    localparam logic [4:0] OP_NEG  = 5'h10;
    localparam logic [4:0] OP_NOT  = 5'h11;
    localparam logic [4:0] OP_BR   = 5'h12;
    localparam logic [4:0] OP_JR   = 5'h13;
    localparam logic [4:0] OP_JAL  = 5'h14;
    localparam logic [4:0] OP_IN   = 5'h15;
    localparam logic [4:0] OP_OUT  = 5'h16;
    localparam logic [4:0] OP_MFHI = 5'h17;
    localparam logic [4:0] OP_MFLO = 5'h18;
    localparam logic [4:0] OP_NOP  = 5'h19;
    localparam logic [4:0] OP_HALT = 5'h1A;

    localparam logic [3:0] B_NONE   = 4'd0;
    localparam logic [3:0] B_ROUT   = 4'd1;
    localparam logic [3:0] B_BAOUT  = 4'd2;
    localparam logic [3:0] B_COUT   = 4'd3;
    localparam logic [3:0] B_PC     = 4'd4;
    localparam logic [3:0] B_MDR    = 4'd5;
    localparam logic [3:0] B_ZLO    = 4'd6;
    localparam logic [3:0] B_ZHI    = 4'd7;
    localparam logic [3:0] B_LO     = 4'd8;
    localparam logic [3:0] B_HI     = 4'd9;
    localparam logic [3:0] B_INPORT = 4'd10;

    localparam logic [2:0] R_NONE = 3'd0;
    localparam logic [2:0] R_GRA  = 3'd1;
    localparam logic [2:0] R_GRB  = 3'd2;
    localparam logic [2:0] R_GRC  = 3'd3;
    localparam logic [2:0] R_R15  = 3'd4;

    localparam int unsigned L_RIN      = 0;
    localparam int unsigned L_PCIN     = 1;
    localparam int unsigned L_IRIN     = 2;
    localparam int unsigned L_MARIN    = 3;
    localparam int unsigned L_MDRIN    = 4;
    localparam int unsigned L_YIN      = 5;
    localparam int unsigned L_ZIN      = 6;
    localparam int unsigned L_LOIN     = 7;
    localparam int unsigned L_HIIN     = 8;
    localparam int unsigned L_CONIN    = 9;
    localparam int unsigned L_OUTPORTIN = 10;

    localparam logic [3:0] A_NONE = 4'd0;
    localparam logic [3:0] A_ADD  = 4'd1;
    localparam logic [3:0] A_AND  = 4'd7;
    localparam logic [3:0] A_OR   = 4'd8;
    localparam logic [3:0] A_MUL  = 4'd9;
    localparam logic [3:0] A_DIV  = 4'd10;
    localparam logic [3:0] A_NEG  = 4'd11;
    localparam logic [3:0] A_NOT  = 4'd12;

    typedef enum logic [3:0] {
        S_RST, S_HALT, S_F0, S_F1, S_F2, S_F3, S_T0, S_T1, S_T2, S_T3, S_T4
    } state_t;

    state_t             state, state_nxt, done_st;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               fault_set;
    logic [4:0]         opc;
    logic               is_alu3, is_imm, is_muldiv, is_negnot, is_mem;
    logic               last_step, mem_wait, mem_timeout, mul_hold, mul_done;
    logic [3:0]         alu_sel;
    logic               ir_unused;

    // Register fields are resolved by the datapath's Gra/Grb/Grc select logic.
    assign ir_unused = ^IR[26:0];

    assign opc         = IR[31:27];
    assign is_alu3     = (opc >= OP_ADD) && (opc <= OP_OR);
    assign is_imm      = (opc >= OP_ADDI) && (opc <= OP_ORI);
    assign is_muldiv   = (opc == OP_MUL) || (opc == OP_DIV);
    assign is_negnot   = (opc == OP_NEG) || (opc == OP_NOT);
    assign is_mem      = (opc <= OP_ST);
    assign mem_wait    = (state == S_F2) || ((state == S_T3) && (opc == OP_LD))
                       || ((state == S_T4) && (opc == OP_ST));
    assign mem_timeout = (MEM_TIMEOUT != 0) && (cnt == CNT_W'(MEM_TIMEOUT - 1));
    assign mul_hold    = (state == S_T1) && is_muldiv;
    assign mul_done    = (cnt == CNT_W'(MULDIV_CYCLES - 1));
    assign done_st     = Stop ? S_HALT : S_F0;

    // Final execute step of each opcode
    always_comb begin
        last_step = 1'b0;
        if (is_alu3 || is_imm || (opc == OP_LDI))          last_step = (state == S_T2);
        else if (is_muldiv || (opc == OP_BR))              last_step = (state == S_T3);
        else if ((opc == OP_LD) || (opc == OP_ST))         last_step = (state == S_T4);
        else if (is_negnot || (opc == OP_JAL))             last_step = (state == S_T1);
        else                                               last_step = (state == S_T0);
    end

    // Three-operand opcodes 03-0A map onto AluOp 1-8 in order
    always_comb begin
        alu_sel = A_NONE;
        case (opc)
            OP_ADDI: alu_sel = A_ADD;
            OP_ANDI: alu_sel = A_AND;
            OP_ORI:  alu_sel = A_OR;
            OP_MUL:  alu_sel = A_MUL;
            OP_DIV:  alu_sel = A_DIV;
            OP_NEG:  alu_sel = A_NEG;
            OP_NOT:  alu_sel = A_NOT;
            default: if (is_alu3) alu_sel = 4'(opc - 5'd2);
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= S_RST;
            cnt   <= '0;
            Fault <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (fault_set) Fault <= 1'b1;
        end
    end

    // Next state: memory waits and MUL/DIV hold stall the current step
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        fault_set = 1'b0;
        if (mem_wait && !MemReady) begin
            if (mem_timeout) begin
                state_nxt = S_HALT;
                fault_set = 1'b1;
            end else if (MEM_TIMEOUT != 0) begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end else if (mul_hold && !mul_done) begin
            cnt_nxt = cnt + CNT_W'(1);
        end else begin
            case (state)
                S_RST:  state_nxt = S_F0;
                S_HALT: if (Go && !Fault) state_nxt = S_F0;
                S_F0:   state_nxt = S_F1;
                S_F1:   state_nxt = S_F2;
                S_F2:   state_nxt = S_F3;
                S_F3: begin
                    if (opc == OP_HALT)      state_nxt = S_HALT;
                    else if (opc >= OP_NOP)  state_nxt = done_st;
                    else                     state_nxt = S_T0;
                end
                S_T0:   state_nxt = last_step ? done_st : S_T1;
                S_T1:   state_nxt = last_step ? done_st : S_T2;
                S_T2:   state_nxt = last_step ? done_st : S_T3;
                S_T3:   state_nxt = last_step ? done_st : S_T4;
                S_T4:   state_nxt = done_st;
                default: state_nxt = S_RST;
            endcase
        end
    end

    // Moore control-word decode
    always_comb begin
        Run     = (state != S_RST) && (state != S_HALT);
        Illegal = 1'b0;
        BusSel  = B_NONE;
        RegSel  = R_NONE;
        Ld      = '0;
        IncPC   = 1'b0;
        Read    = 1'b0;
        Write   = 1'b0;
        AluOp   = A_NONE;
        case (state)
            S_F0: begin BusSel = B_PC; Ld[L_MARIN] = 1'b1; Ld[L_ZIN] = 1'b1; IncPC = 1'b1; end
            S_F1: begin BusSel = B_ZLO; Ld[L_PCIN] = 1'b1; end
            S_F2: begin Read = 1'b1; Ld[L_MDRIN] = 1'b1; end
            S_F3: begin BusSel = B_MDR; Ld[L_IRIN] = 1'b1; Illegal = (opc > OP_HALT); end
            S_T0, S_T1, S_T2, S_T3, S_T4: begin
                if (is_alu3 || is_imm) begin
                    case (state)
                        S_T0: begin RegSel = R_GRB; BusSel = B_ROUT; Ld[L_YIN] = 1'b1; end
                        S_T1: begin
                            RegSel    = is_alu3 ? R_GRC : R_NONE;
                            BusSel    = is_alu3 ? B_ROUT : B_COUT;
                            AluOp     = alu_sel;
                            Ld[L_ZIN] = 1'b1;
                        end
                        S_T2: begin BusSel = B_ZLO; RegSel = R_GRA; Ld[L_RIN] = 1'b1; end
                        default: ;
                    endcase
                end else if (is_muldiv) begin
                    case (state)
                        S_T0: begin RegSel = R_GRA; BusSel = B_ROUT; Ld[L_YIN] = 1'b1; end
                        S_T1: begin RegSel = R_GRB; BusSel = B_ROUT; AluOp = alu_sel; Ld[L_ZIN] = 1'b1; end
                        S_T2: begin BusSel = B_ZLO; Ld[L_LOIN] = 1'b1; end
                        S_T3: begin BusSel = B_ZHI; Ld[L_HIIN] = 1'b1; end
                        default: ;
                    endcase
                end else if (is_negnot) begin
                    case (state)
                        S_T0: begin RegSel = R_GRB; BusSel = B_ROUT; AluOp = alu_sel; Ld[L_ZIN] = 1'b1; end
                        S_T1: begin BusSel = B_ZLO; RegSel = R_GRA; Ld[L_RIN] = 1'b1; end
                        default: ;
                    endcase
                end else if (is_mem) begin
                    case (state)
                        S_T0: begin RegSel = R_GRB; BusSel = B_BAOUT; Ld[L_YIN] = 1'b1; end
                        S_T1: begin BusSel = B_COUT; AluOp = A_ADD; Ld[L_ZIN] = 1'b1; end
                        S_T2: begin
                            BusSel = B_ZLO;
                            if (opc == OP_LDI) begin RegSel = R_GRA; Ld[L_RIN] = 1'b1; end
                            else               Ld[L_MARIN] = 1'b1;
                        end
                        S_T3: begin
                            if (opc == OP_LD) begin Read = 1'b1; Ld[L_MDRIN] = 1'b1; end
                            else if (opc == OP_ST) begin RegSel = R_GRA; BusSel = B_ROUT; Ld[L_MDRIN] = 1'b1; end
                        end
                        S_T4: begin
                            if (opc == OP_LD) begin BusSel = B_MDR; RegSel = R_GRA; Ld[L_RIN] = 1'b1; end
                            else if (opc == OP_ST) Write = 1'b1;
                        end
                        default: ;
                    endcase
                end else begin
                    case (opc)
                        OP_BR: begin
                            case (state)
                                S_T0: begin RegSel = R_GRA; BusSel = B_ROUT; Ld[L_CONIN] = 1'b1; end
                                S_T1: begin BusSel = B_PC; Ld[L_YIN] = 1'b1; end
                                S_T2: begin BusSel = B_COUT; AluOp = A_ADD; Ld[L_ZIN] = 1'b1; end
                                S_T3: if (CON_FF) begin BusSel = B_ZLO; Ld[L_PCIN] = 1'b1; end
                                default: ;
                            endcase
                        end
                        OP_JR: if (state == S_T0) begin RegSel = R_GRA; BusSel = B_ROUT; Ld[L_PCIN] = 1'b1; end
                        OP_JAL: begin
                            if (state == S_T0) begin BusSel = B_PC; RegSel = R_R15; Ld[L_RIN] = 1'b1; end
                            else if (state == S_T1) begin RegSel = R_GRA; BusSel = B_ROUT; Ld[L_PCIN] = 1'b1; end
                        end
                        OP_IN:   if (state == S_T0) begin BusSel = B_INPORT; RegSel = R_GRA; Ld[L_RIN] = 1'b1; end
                        OP_OUT:  if (state == S_T0) begin RegSel = R_GRA; BusSel = B_ROUT; Ld[L_OUTPORTIN] = 1'b1; end
                        OP_MFHI: if (state == S_T0) begin BusSel = B_HI; RegSel = R_GRA; Ld[L_RIN] = 1'b1; end
                        OP_MFLO: if (state == S_T0) begin BusSel = B_LO; RegSel = R_GRA; Ld[L_RIN] = 1'b1; end
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl_seq.sv
// Scoreboard bench for multicycle_ctrl_seq: per-cycle input/expected-output records are
// queued per scenario and popped and compared as the sequencer steps.
module tb_multicycle_ctrl_seq;

    localparam int unsigned MULDIV_CYCLES = 3;
    localparam int unsigned MEM_TIMEOUT   = 4;

    localparam logic [31:0] IR_ADD  = 32'h19888000;
    localparam logic [31:0] IR_LD   = 32'h00900010;
    localparam logic [31:0] IR_ST   = 32'h10900020;
    localparam logic [31:0] IR_ANDI = 32'h6108000F;
    localparam logic [31:0] IR_MUL  = 32'h70880000;
    localparam logic [31:0] IR_NEG  = 32'h80880000;
    localparam logic [31:0] IR_BR   = 32'h90800005;
    localparam logic [31:0] IR_JAL  = 32'hA0800000;
    localparam logic [31:0] IR_OUT  = 32'hB0800000;
    localparam logic [31:0] IR_MFHI = 32'hB8800000;
    localparam logic [31:0] IR_NOP  = 32'hC8000000;
    localparam logic [31:0] IR_HALT = 32'hD0000000;
    localparam logic [31:0] IR_ILL  = 32'hE0000000;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [31:0] IR;
    logic        CON_FF, MemReady, Stop, Go;
    logic        Run, Fault, Illegal, IncPC, Read, Write;
    logic [3:0]  BusSel, AluOp;
    logic [2:0]  RegSel;
    logic [10:0] Ld;

    typedef struct packed {
        logic        run;
        logic        fault;
        logic        illegal;
        logic [3:0]  bus;
        logic [2:0]  rsel;
        logic [10:0] ld;
        logic        inc;
        logic        rd;
        logic        wr;
        logic [3:0]  alu;
    } outv_t;

    typedef struct packed {
        logic [31:0] ir;
        logic        mr;
        logic        stop;
        logic        go;
        logic        con;
        outv_t       exp;
    } rec_t;

    rec_t sb[$];
    int   checks = 0;
    int   errors = 0;

    multicycle_ctrl_seq #(.MULDIV_CYCLES(MULDIV_CYCLES), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .Clock(Clock), .Reset(Reset), .IR(IR), .CON_FF(CON_FF), .MemReady(MemReady),
        .Stop(Stop), .Go(Go), .Run(Run), .Fault(Fault), .Illegal(Illegal),
        .BusSel(BusSel), .RegSel(RegSel), .Ld(Ld), .IncPC(IncPC), .Read(Read),
        .Write(Write), .AluOp(AluOp)
    );

    always #5 Clock = ~Clock;

    function automatic outv_t observed();
        outv_t v;
        v.run = Run; v.fault = Fault; v.illegal = Illegal; v.bus = BusSel; v.rsel = RegSel;
        v.ld = Ld; v.inc = IncPC; v.rd = Read; v.wr = Write; v.alu = AluOp;
        return v;
    endfunction

    // Expected running-state control word; irw = {IncPC, Read, Write}
    function automatic outv_t ex(input logic [3:0] bus, input logic [2:0] rsel,
                                 input logic [10:0] ld, input logic [3:0] alu, input logic [2:0] irw);
        outv_t v;
        v = '0;
        v.run = 1'b1; v.bus = bus; v.rsel = rsel; v.ld = ld; v.alu = alu;
        {v.inc, v.rd, v.wr} = irw;
        return v;
    endfunction

    task automatic push(input logic [31:0] ir, input logic mr, input logic stop, input logic go,
                        input logic con, input outv_t e);
        rec_t r;
        r.ir = ir; r.mr = mr; r.stop = stop; r.go = go; r.con = con; r.exp = e;
        sb.push_back(r);
    endtask

    task automatic push_fetch(input logic [31:0] ir, input int waits, input logic illegal);
        outv_t f3;
        push(ir, 1'b1, 1'b0, 1'b0, 1'b0, ex(4'd4, 3'd0, 11'h048, 4'd0, 3'b100));
        push(ir, 1'b1, 1'b0, 1'b0, 1'b0, ex(4'd6, 3'd0, 11'h002, 4'd0, 3'b000));
        for (int i = 0; i < waits; i++)
            push(ir, 1'b0, 1'b0, 1'b0, 1'b0, ex(4'd0, 3'd0, 11'h010, 4'd0, 3'b010));
        push(ir, 1'b1, 1'b0, 1'b0, 1'b0, ex(4'd0, 3'd0, 11'h010, 4'd0, 3'b010));
        f3 = ex(4'd5, 3'd0, 11'h004, 4'd0, 3'b000);
        f3.illegal = illegal;
        push(ir, 1'b1, 1'b0, 1'b0, 1'b0, f3);
    endtask

    task automatic apply(input rec_t r);
        IR = r.ir; MemReady = r.mr; Stop = r.stop; Go = r.go; CON_FF = r.con;
    endtask

    task automatic test_reset();
        Reset = 1'b1; IR = '0; CON_FF = 1'b0; MemReady = 1'b0; Stop = 1'b0; Go = 1'b0;
        repeat (2) @(negedge Clock);
        #1;
        checks++;
        if (observed() !== outv_t'(0)) begin
            errors++; $display("FAIL reset_held: got %h expected %h", observed(), outv_t'(0));
        end
        Reset = 1'b0;
        #1;
        checks++;
        if (observed() !== outv_t'(0)) begin
            errors++; $display("FAIL reset_release: got %h expected %h", observed(), outv_t'(0));
        end
    endtask

    task automatic test_add();
        rec_t r;
        int n = 0;
        push_fetch(IR_ADD, 0, 1'b0);
        push(IR_ADD, 1'b1, 1'b0, 1'b0, 1'b0, ex(4'd1, 3'd2, 11'h020, 4'd0, 3'b000));
        push(IR_ADD, 1'b1, 1'b0, 1'b0, 1'b0, ex(4'd1, 3'd3, 11'h040, 4'd1, 3'b000));
        push(IR_ADD, 1'b1, 1'b0, 1'b0, 1'b0, ex(4'd6, 3'd1, 11'h001, 4'd0, 3'b000));
        while (sb.size() != 0) begin
            r = sb.pop_front();
            @(negedge Clock); apply(r); #1;
            checks++;
            if (observed() !== r.exp) begin
                errors++; $display("FAIL add step %0d: got %h expected %h", n, observed(), r.exp);
            end
            n++;
        end
    endtask

    task automatic test_ld_wait();
        rec_t r;
        int n = 0;
        push_fetch(IR_LD, 0, 1'b0);
        push(IR_LD, 1'b1, 1'b0, 1'b0, 1'b0, ex(4'd2, 3'd2, 11'h020, 4'd0, 3'b000));
        push(IR_LD, 1'b1, 1'b0, 1'b0, 1'b0, ex(4'd3, 3'd0, 11'h040, 4'd1, 3'b000));
        push(IR_LD, 1'b1, 1'b0, 1'b0, 1'b0, ex(4'd6, 3'd0, 11'h008, 4'd0, 3'b000));
        for (int i = 0; i < 3; i++)
            push(IR_LD, 1'b0, 1'b0, 1'b0, 1'b0, ex(4'd0, 3'd0, 11'h010, 4'd0, 3'b010));
        push(IR_LD, 1'b1, 1'b0, 1'b0, 1'b0, ex(4'd0, 3'd0, 11'h010, 4'd0, 3'b010));
        push(IR_LD, 1'b1, 1'b0, 1'b0, 1'b0, ex(4'd5, 3'd1, 11'h001, 4'd0, 3'b000));
        while (sb.size() != 0) begin
            r = sb.pop_front();
            @(negedge Clock); apply(r); #1;
            checks++;
            if (observed() !== r.exp) begin
                errors++; $display("FAIL ld_wait step %0d: got %h expected %h", n, observed(), r.exp);
            end
            n++;
        end
    endtask

    task automatic test_br();
        rec_t r;
        int n = 0;
        for (int t = 1; t >= 0; t--) begin
            push_fetch(IR_BR, 0, 1'b0);
            push(IR_BR, 1'b1, 1'b0, 1'b0, 1'b0, ex(4'd1, 3'd1, 11'h200, 4'd0, 3'b000));
            push(IR_BR, 1'b1, 1'b0, 1'b0, 1'b0, ex(4'd4, 3'd0, 11'h020, 4'd0, 3'b000));
            push(IR_BR, 1'b1, 1'b0, 1'b0, 1'b0, ex(4'd3, 3'd0, 11'h040, 4'd1, 3'b000));
            if (t == 1) push(IR_BR, 1'b1, 1'b0, 1'b0, 1'b1, ex(4'd6, 3'd0, 11'h002, 4'd0, 3'b000));
            else        push(IR_BR, 1'b1, 1'b0, 1'b0, 1'b0, ex(4'd0, 3'd0, 11'h000, 4'd0, 3'b000));
        end
        while (sb.size() != 0) begin
            r = sb.pop_front();
            @(negedge Clock); apply(r); #1;
            checks++;
            if (observed() !== r.exp) begin
                errors++; $display("FAIL br step %0d: got %h expected %h", n, observed(), r.exp);
            end
            n++;
        end
    endtask

    task automatic test_mul();
        rec_t r;
        int n = 0;
        push_fetch(IR_MUL, 0, 1'b0);
        push(IR_MUL, 1'b1, 1'b0, 1'b0, 1'b0, ex(4'd1, 3'd1, 11'h020, 4'd0, 3'b000));
        for (int i = 0; i < int'(MULDIV_CYCLES); i++)
            push(IR_MUL, 1'b1, 1'b0, 1'b0, 1'b0, ex(4'd1, 3'd2, 11'h040, 4'd9, 3'b000));
        push(IR_MUL, 1'b1, 1'b0, 1'b0, 1'b0, ex(4'd6, 3'd0, 11'h080, 4'd0, 3'b000));
        push(IR_MUL, 1'b1, 1'b0, 1'b0, 1'b0, ex(4'd7, 3'd0, 11'h100, 4'd0, 3'b000));
        while (sb.size() != 0) begin
            r = sb.pop_front();
            @(negedge Clock); apply(r); #1;
            checks++;
            if (observed() !== r.exp) begin
                errors++; $display("FAIL mul step %0d: got %h expected %h", n, observed(), r.exp);
            end
            n++;
        end
    endtask

    task automatic test_misc();
        rec_t r;
        int n = 0;
        push_fetch(IR_ANDI, 0, 1'b0);
        push(IR_ANDI, 1'b1, 1'b0, 1'b0, 1'b0, ex(4'd1, 3'd2, 11'h020, 4'd0, 3'b000));
        push(IR_ANDI, 1'b1, 1'b0, 1'b0, 1'b0, ex(4'd3, 3'd0, 11'h040, 4'd7, 3'b000));
        push(IR_ANDI, 1'b1, 1'b0, 1'b0, 1'b0, ex(4'd6, 3'd1, 11'h001, 4'd0, 3'b000));
        push_fetch(IR_NEG, 0, 1'b0);
        push(IR_NEG, 1'b1, 1'b0, 1'b0, 1'b0, ex(4'd1, 3'd2, 11'h040, 4'd11, 3'b000));
        push(IR_NEG, 1'b1, 1'b0, 1'b0, 1'b0, ex(4'd6, 3'd1, 11'h001, 4'd0, 3'b000));
        push_fetch(IR_ST, 2, 1'b0);
        push(IR_ST, 1'b1, 1'b0, 1'b0, 1'b0, ex(4'd2, 3'd2, 11'h020, 4'd0, 3'b000));
        push(IR_ST, 1'b1, 1'b0, 1'b0, 1'b0, ex(4'd3, 3'd0, 11'h040, 4'd1, 3'b000));
        push(IR_ST, 1'b1, 1'b0, 1'b0, 1'b0, ex(4'd6, 3'd0, 11'h008, 4'd0, 3'b000));
        push(IR_ST, 1'b1, 1'b0, 1'b0, 1'b0, ex(4'd1, 3'd1, 11'h010, 4'd0, 3'b000));
        push(IR_ST, 1'b0, 1'b0, 1'b0, 1'b0, ex(4'd0, 3'd0, 11'h000, 4'd0, 3'b001));
        push(IR_ST, 1'b1, 1'b0, 1'b0, 1'b0, ex(4'd0, 3'd0, 11'h000, 4'd0, 3'b001));
        push_fetch(IR_JAL, 0, 1'b0);
        push(IR_JAL, 1'b1, 1'b0, 1'b0, 1'b0, ex(4'd4, 3'd4, 11'h001, 4'd0, 3'b000));
        push(IR_JAL, 1'b1, 1'b0, 1'b0, 1'b0, ex(4'd1, 3'd1, 11'h002, 4'd0, 3'b000));
        push_fetch(IR_OUT, 0, 1'b0);
        push(IR_OUT, 1'b1, 1'b0, 1'b0, 1'b0, ex(4'd1, 3'd1, 11'h400, 4'd0, 3'b000));
        push_fetch(IR_MFHI, 0, 1'b0);
        push(IR_MFHI, 1'b1, 1'b0, 1'b0, 1'b0, ex(4'd9, 3'd1, 11'h001, 4'd0, 3'b000));
        push_fetch(IR_NOP, 0, 1'b0);
        push_fetch(IR_ILL, 0, 1'b1);
        while (sb.size() != 0) begin
            r = sb.pop_front();
            @(negedge Clock); apply(r); #1;
            checks++;
            if (observed() !== r.exp) begin
                errors++; $display("FAIL misc step %0d: got %h expected %h", n, observed(), r.exp);
            end
            n++;
        end
    endtask

    task automatic test_stop_go();
        rec_t r;
        int n = 0;
        push_fetch(IR_ADD, 0, 1'b0);
        push(IR_ADD, 1'b1, 1'b0, 1'b0, 1'b0, ex(4'd1, 3'd2, 11'h020, 4'd0, 3'b000));
        push(IR_ADD, 1'b1, 1'b1, 1'b0, 1'b0, ex(4'd1, 3'd3, 11'h040, 4'd1, 3'b000));
        push(IR_ADD, 1'b1, 1'b1, 1'b0, 1'b0, ex(4'd6, 3'd1, 11'h001, 4'd0, 3'b000));
        push(IR_ADD, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        push(IR_ADD, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        push(IR_ADD, 1'b1, 1'b0, 1'b1, 1'b0, '0);
        push_fetch(IR_HALT, 0, 1'b0);
        push(IR_HALT, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        push(IR_HALT, 1'b1, 1'b1, 1'b1, 1'b0, '0);
        push_fetch(IR_NOP, 0, 1'b0);
        while (sb.size() != 0) begin
            r = sb.pop_front();
            @(negedge Clock); apply(r); #1;
            checks++;
            if (observed() !== r.exp) begin
                errors++; $display("FAIL stop_go step %0d: got %h expected %h", n, observed(), r.exp);
            end
            n++;
        end
    endtask

    task automatic test_reset_mid();
        rec_t r;
        int n = 0;
        push_fetch(IR_LD, 0, 1'b0);
        push(IR_LD, 1'b1, 1'b0, 1'b0, 1'b0, ex(4'd2, 3'd2, 11'h020, 4'd0, 3'b000));
        push(IR_LD, 1'b1, 1'b0, 1'b0, 1'b0, ex(4'd3, 3'd0, 11'h040, 4'd1, 3'b000));
        push(IR_LD, 1'b1, 1'b0, 1'b0, 1'b0, ex(4'd6, 3'd0, 11'h008, 4'd0, 3'b000));
        push(IR_LD, 1'b0, 1'b0, 1'b0, 1'b0, ex(4'd0, 3'd0, 11'h010, 4'd0, 3'b010));
        while (sb.size() != 0) begin
            r = sb.pop_front();
            @(negedge Clock); apply(r); #1;
            checks++;
            if (observed() !== r.exp) begin
                errors++; $display("FAIL reset_mid step %0d: got %h expected %h", n, observed(), r.exp);
            end
            n++;
        end
        Reset = 1'b1;
        #1;
        checks++;
        if (observed() !== outv_t'(0)) begin
            errors++; $display("FAIL reset_mid async: got %h expected %h", observed(), outv_t'(0));
        end
        @(negedge Clock);
        Reset = 1'b0; MemReady = 1'b1;
        #1;
        checks++;
        if (observed() !== outv_t'(0)) begin
            errors++; $display("FAIL reset_mid release: got %h expected %h", observed(), outv_t'(0));
        end
    endtask

    task automatic test_timeout();
        rec_t  r;
        outv_t hf;
        int    n = 0;
        hf = '0;
        hf.fault = 1'b1;
        push(IR_NOP, 1'b1, 1'b0, 1'b0, 1'b0, ex(4'd4, 3'd0, 11'h048, 4'd0, 3'b100));
        push(IR_NOP, 1'b1, 1'b0, 1'b0, 1'b0, ex(4'd6, 3'd0, 11'h002, 4'd0, 3'b000));
        for (int i = 0; i < int'(MEM_TIMEOUT); i++)
            push(IR_NOP, 1'b0, 1'b0, 1'b0, 1'b0, ex(4'd0, 3'd0, 11'h010, 4'd0, 3'b010));
        push(IR_NOP, 1'b0, 1'b0, 1'b1, 1'b0, hf);
        push(IR_NOP, 1'b1, 1'b0, 1'b1, 1'b0, hf);
        push(IR_NOP, 1'b1, 1'b1, 1'b1, 1'b0, hf);
        push(IR_NOP, 1'b1, 1'b0, 1'b0, 1'b0, hf);
        while (sb.size() != 0) begin
            r = sb.pop_front();
            @(negedge Clock); apply(r); #1;
            checks++;
            if (observed() !== r.exp) begin
                errors++; $display("FAIL timeout step %0d: got %h expected %h", n, observed(), r.exp);
            end
            n++;
        end
        Reset = 1'b1;
        #1;
        checks++;
        if (observed() !== outv_t'(0)) begin
            errors++; $display("FAIL fault_clear: got %h expected %h", observed(), outv_t'(0));
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_ld_wait();
        test_br();
        test_mul();
        test_misc();
        test_stop_go();
        test_reset_mid();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
